load_store_unit: RTL and testbench

//  - Sits between the single-cycle core's ALU/register-file stage and the data memory bus; replaces the zero-latency DMEM port.
//  - Accepts one load/store per request, drives a valid/ready memory bus, builds byte strobes and sign/zero-extends load data.
//  - Holds `stall` high while the access is in flight, so the core freezes PC and register-file writes until rsp_valid.

---
 rtl/load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between the core's
// execute stage and a valid/ready data-memory bus. Builds byte strobes and
// lane-replicated store data, sign/zero-extends load data, and holds stall
// high while an access is in flight.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/W accesses complete at once with rsp_err=1
//   undefined -> misaligned low address bits are silently truncated
//
// Ports:
//   clk, rst_n      clock, synchronous active-high reset
//   req_*           core request (valid/ready, we, funct3, addr, wdata)
//   rsp_*           one-cycle completion pulse with load data and error flag
//   stall           core freeze while busy
//   mem_*           data-memory bus (request handshake + read-data return)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_f3_illegal;
  logic               w_misalign;
  logic               w_reject;
  logic               w_timeout;
  logic [3:0]         w_strb;
  logic [31:0]        w_lanes;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load_data;

  // Request decode: illegal width codes, and loads-only widths on stores
  always_comb begin
    w_f3_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    w_misalign   = 1'b0;
`endif
    w_reject     = w_f3_illegal || w_misalign;
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Store lane steering; misaligned low bits drop out via the lane shifts
  always_comb begin
    w_strb  = 4'b1111;
    w_lanes = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << r_addr[1:0];
        w_lanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << {r_addr[1], 1'b0};
        w_lanes = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extract and extension
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    stall     = 1'b1;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          w_next = w_reject ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        mem_valid = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[31:2], 2'b00};
        if (r_we) begin
          mem_wstrb = w_strb;
          mem_wdata = w_lanes;
        end
        if (mem_ready) begin
          w_next = r_we ? S_RESP : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = r_rdata;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latch, read-data capture and timeout counter
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= 32'd0;
        r_err    <= w_reject;
      end
      if (r_state == S_WAIT_R) begin
        // Data wins over a timeout landing in the same cycle
        if (mem_rvalid) begin
          r_rdata <= w_load_data;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end
      end
      if ((r_state == S_WAIT_R) && (w_next == S_WAIT_R)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit. A transaction-level
// model (lane arithmetic, expected bus timeline) produces per-cycle expected
// outputs; literal checks pin the model on the headline cases.
module tb_load_store_unit;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .stall      (stall),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int mv_cnt  = 0;
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  int acc_cyc = 0;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_strb;
  logic        cap_err;

  logic        chk_en, chk_all;
  logic        exp_req_ready, exp_stall, exp_mem_valid, exp_mem_we;
  logic        exp_rsp_valid, exp_rsp_err;
  logic [31:0] exp_mem_addr, exp_mem_wdata, exp_rsp_rdata;
  logic [3:0]  exp_mem_wstrb;

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = acc_size(f3);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic e;
    e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 >= 3'd4));
`ifdef LSU_MISALIGN_TRAP_EN
    if (!e && (lane_base(f3, a) != int'(a[1:0]))) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int b, n;
    b = lane_base(f3, a);
    n = acc_size(f3);
    for (int i = 0; i < 4; i++) s[i] = (i >= b) && (i < b + n);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] o;
    int n;
    n = acc_size(f3);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    logic [31:0] v, mask;
    int n;
    n    = acc_size(f3);
    v    = d >> (8 * lane_base(f3, a));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (!f3[2] && (n < 4) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_cycle();
    cyc++;
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_req_ready));
      chk("stall",     32'(stall),     32'(exp_stall));
      chk("mem_valid", 32'(mem_valid), 32'(exp_mem_valid));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      if (exp_mem_valid || chk_all) begin
        chk("mem_we",    32'(mem_we),    32'(exp_mem_we));
        chk("mem_addr",  mem_addr,       exp_mem_addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_mem_wstrb));
        if (exp_mem_we || chk_all) chk("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_rsp_valid || chk_all) begin
        chk("rsp_err",   32'(rsp_err), 32'(exp_rsp_err));
        chk("rsp_rdata", rsp_rdata,    exp_rsp_rdata);
      end
    end
    if (mem_valid === 1'b1) begin
      mv_cnt++;
      cap_addr  = mem_addr;
      cap_strb  = mem_wstrb;
      cap_wdata = mem_wdata;
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc   = cyc;
      cap_rdata = rsp_rdata;
      cap_err   = rsp_err;
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_req_ready = 1'b1; exp_stall = 1'b0; exp_mem_valid = 1'b0; exp_mem_we = 1'b0;
    exp_mem_addr = 32'd0; exp_mem_wstrb = 4'd0; exp_mem_wdata = 32'd0;
    exp_rsp_valid = 1'b0; exp_rsp_err = 1'b0; exp_rsp_rdata = 32'd0;
    chk_all = 1'b1;
  endtask

  task automatic set_busy_exp();
    set_idle_exp();
    exp_req_ready = 1'b0; exp_stall = 1'b1; chk_all = 1'b0;
  endtask

  // One access. rv_dly = cycles after the handshake until rvalid (0 = never).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rdy_dly, input int rv_dly,
                         input logic [31:0] rdata, input logic hold);
    logic e, tmo;
    int mv0, rsp0, n, lat;
    e    = model_err(we, f3, addr);
    tmo  = 1'b0;
    mv0  = mv_cnt;
    rsp0 = rsp_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    set_idle_exp();
    exp_stall = 1'b1;
    step();
    acc_cyc = cyc;
    // A held request with changed fields must have no effect while busy
    req_valid = hold;
    if (hold) begin
      req_we = ~we; req_funct3 = 3'b010; req_addr = ~addr; req_wdata = ~wdata;
    end
    set_busy_exp();
    n = 0;
    if (!e) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        mem_ready  = (k == rdy_dly);
        mem_rvalid = (k == rdy_dly);        // same-cycle rvalid must be ignored
        mem_rdata  = ~rdata;
        exp_mem_valid = 1'b1;
        exp_mem_we    = we;
        exp_mem_addr  = {addr[31:2], 2'b00};
        exp_mem_wstrb = we ? model_strb(f3, addr) : 4'd0;
        exp_mem_wdata = model_wdata(f3, wdata);
        step();
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      set_busy_exp();
      if (!we) begin
        n   = (rv_dly > 0) ? rv_dly : int'(TMO);
        tmo = (rv_dly == 0);
        for (int w = 1; w <= n; w++) begin
          mem_rvalid = (rv_dly > 0) && (w == rv_dly);
          mem_rdata  = mem_rvalid ? rdata : 32'h0BAD_F00D;
          step();
        end
        mem_rvalid = 1'b0;
      end
    end
    req_valid     = 1'b0;
    exp_rsp_valid = 1'b1;
    exp_rsp_err   = e || tmo;
    exp_rsp_rdata = (e || tmo || we) ? 32'd0 : model_load(f3, addr, rdata);
    step();
    set_idle_exp();
    step();
    lat = e ? 1 : (we ? rdy_dly + 2 : rdy_dly + n + 2);
    chk("rsp_pulses", 32'(rsp_cnt - rsp0), 32'd1);
    chk("bus_cycles", 32'(mv_cnt - mv0), e ? 32'd0 : 32'(rdy_dly + 1));
    chk("latency",    32'(rsp_cyc - acc_cyc), 32'(lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0; chk_en = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
    chk_en = 1'b1;
    step();                       // reset state while reset still held
    rst_n = 1'b0;
    step();

    // SW 0x100: full word, third cycle counting the accept cycle
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0, 1'b0);
    chk("sw_addr",  cap_addr, 32'h100);
    chk("sw_strb",  32'(cap_strb), 32'hF);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_lat",   32'(rsp_cyc - acc_cyc), 32'd2);
    chk("sw_err",   32'(cap_err), 32'd0);

    // SB 0x103 with the request held high and altered while busy
    run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'd0, 1'b1);
    chk("sb_strb",  32'(cap_strb), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);

    // SH 0x102 with one wait state
    run_txn(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1, 0, 32'd0, 1'b0);
    chk("sh_strb",  32'(cap_strb), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);

    // Loads from 0x102 of 0x12C45678
    run_txn(1'b0, 3'b000, 32'h102, 32'd0, 0, 1, 32'h12C45678, 1'b0);
    chk("lb_data", cap_rdata, 32'hFFFFFFC4);
    chk("lb_lat",  32'(rsp_cyc - acc_cyc), 32'd3);
    run_txn(1'b0, 3'b100, 32'h102, 32'd0, 0, 1, 32'h12C45678, 1'b0);
    chk("lbu_data", cap_rdata, 32'h000000C4);
    run_txn(1'b0, 3'b101, 32'h102, 32'd0, 0, 1, 32'h12C45678, 1'b0);
    chk("lhu_data", cap_rdata, 32'h000012C4);
    run_txn(1'b0, 3'b001, 32'h200, 32'd0, 0, 3, 32'h00008001, 1'b0);
    chk("lh_data", cap_rdata, 32'hFFFF8001);

    // LW with a slow bus: five ready-low cycles, rvalid two cycles later
    run_txn(1'b0, 3'b010, 32'h300, 32'd0, 5, 2, 32'hCAFEF00D, 1'b1);
    chk("lw_slow_data", cap_rdata, 32'hCAFEF00D);

    // LW with no read data: timeout after TMO waiting cycles
    run_txn(1'b0, 3'b010, 32'h400, 32'd0, 0, 0, 32'd0, 1'b0);
    chk("tmo_err",  32'(cap_err), 32'd1);
    chk("tmo_data", cap_rdata, 32'd0);
    chk("tmo_lat",  32'(rsp_cyc - acc_cyc), 32'(TMO + 2));

    // LH 0x101: trapped or truncated depending on the build
    r0 = mv_cnt;
    run_txn(1'b0, 3'b001, 32'h101, 32'd0, 0, 1, 32'h12C45678, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", 32'(cap_err), 32'd1);
    chk("mis_bus", 32'(mv_cnt - r0), 32'd0);
`else
    chk("mis_addr", cap_addr, 32'h100);
    chk("mis_data", cap_rdata, 32'h00005678);
    chk("mis_err",  32'(cap_err), 32'd0);
`endif

    // Illegal width codes never reach the bus
    run_txn(1'b0, 3'b011, 32'h500, 32'd0, 0, 1, 32'd0, 1'b0);
    chk("ill_ld_err", 32'(cap_err), 32'd1);
    run_txn(1'b1, 3'b100, 32'h500, 32'h11, 0, 0, 32'd0, 1'b0);
    chk("ill_st_err", 32'(cap_err), 32'd1);

    // Reset in the middle of a bus request
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
    set_idle_exp(); exp_stall = 1'b1;
    step();
    req_valid = 1'b0;
    set_busy_exp();
    exp_mem_valid = 1'b1; exp_mem_addr = 32'h600;
    step();
    rst_n = 1'b1; chk_en = 1'b0;
    step();
    rst_n = 1'b0; chk_en = 1'b1;
    set_idle_exp();
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
